// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame width and
// the line levels of the start and stop bits (also used by a future uart_tx).
package uart_pkg;

  localparam int DEFAULT_DATA_BITS = 8;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/rx_sync.sv
// Multi-stage synchroniser for the asynchronous serial line. Every stage
// resets to 1 so the line reads idle straight out of reset.
module rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic rx,
  output logic rx_s
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], rx};
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would collapse the stages into one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rx_s = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1-style UART receiver. It holds the external baud generator cleared while
// idle so that each baud_tick after the start edge lands mid-bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = DEFAULT_DATA_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 baud_tick,
  output logic                 baud_clear,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  logic rx_s;

  rx_sync #(
    .STAGES (SYNC_STAGES)
  ) u_rx_sync (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .rx_s  (rx_s)
  );

  rx_state_e            state_q,      state_d;
  logic [DATA_BITS-1:0] shift_q,      shift_d;
  logic [CNT_W-1:0]     cnt_q,        cnt_d;
  logic [DATA_BITS-1:0] data_q,       data_d;
  logic                 valid_q,      valid_d;
  logic                 frame_err_q,  frame_err_d;
  logic                 busy_q,       busy_d;
  logic                 baud_clear_q, baud_clear_d;

  // NOTE: every variable gets a default before the case so that no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (rx_s == START_BIT) state_d = ST_START;
      end
      ST_START: begin
        if (baud_tick) begin
          // A start bit that is high again at mid-bit was a glitch.
          if (rx_s == START_BIT) begin
            state_d = ST_DATA;
            cnt_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (baud_tick) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (cnt_q == LAST_BIT) begin
            state_d = ST_STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (baud_tick) begin
          if (rx_s == STOP_BIT) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_WAIT_HIGH;
          end
        end
      end
      ST_WAIT_HIGH: begin
        // A break keeps the line low; wait it out so it yields one error only.
        if (rx_s == STOP_BIT) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Decoded from the next state so the registered outputs track the FSM
    // in the same cycle as the state register.
    baud_clear_d = (state_d == ST_IDLE) || (state_d == ST_WAIT_HIGH);
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      cnt_q        <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
      baud_clear_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      busy_q       <= busy_d;
      baud_clear_q <= baud_clear_d;
    end
  end

  assign data       = data_q;
  assign valid      = valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = busy_q;
  assign baud_clear = baud_clear_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: models a baudgen (M=104) cleared by baud_clear, drives
// serial frames and checks strobes against a queue of expected results.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int M = 104;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       baud_tick;
  logic       baud_clear;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int valid_cnt = 0;
  int ferr_cnt = 0;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];

  uart_rx #(
    .DATA_BITS   (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .baud_tick  (baud_tick),
    .baud_clear (baud_clear),
    .data       (data),
    .valid      (valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #41.667 clk = ~clk;

  // Baud generator model: synchronous active-high clear, tick mid-bit.
  int bg_cnt;
  always @(posedge clk) begin
    if (baud_clear) begin
      bg_cnt    <= 0;
      baud_tick <= 1'b0;
    end else begin
      bg_cnt    <= (bg_cnt == M - 1) ? 0 : bg_cnt + 1;
      baud_tick <= (bg_cnt == M / 2);
    end
  end

  // Strobe monitor: pops the scoreboard on every valid / frame_err.
  logic       prev_valid = 1'b0;
  logic       prev_ferr = 1'b0;
  logic       prev_reset = 1'b0;
  logic [7:0] prev_data = 8'h00;
  always @(negedge clk) begin
    exp_t e;
    if (valid && frame_err) begin
      errors++;
      $display("FAIL strobe_both: valid=%b frame_err=%b required not both", valid, frame_err);
    end
    if ((valid && prev_valid) || (frame_err && prev_ferr)) begin
      errors++;
      $display("FAIL strobe_width: strobe high two cycles, required one");
    end
    if (reset && prev_reset && !valid && data !== prev_data) begin
      errors++;
      $display("FAIL data_hold: data changed %h -> %h without valid", prev_data, data);
    end
    if (valid || frame_err) begin
      checks++;
      if (valid) valid_cnt++;
      if (frame_err) ferr_cnt++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: valid=%b frame_err=%b data=%h, none expected", valid, frame_err, data);
      end else begin
        e = exp_q.pop_front();
        if (frame_err !== e.is_err || valid !== !e.is_err || data !== e.data) begin
          errors++;
          $display("FAIL scoreboard: got valid=%b frame_err=%b data=%h, required frame_err=%b data=%h",
                   valid, frame_err, data, e.is_err, e.data);
        end
      end
    end
    prev_valid = valid;
    prev_ferr  = frame_err;
    prev_reset = reset;
    prev_data  = data;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic val, input int period);
    rx = val;
    cycles(period);
  endtask

  task automatic send_frame(input logic [7:0] b, input int period, input logic stop_val);
    drive_bit(1'b0, period);
    for (int i = 0; i < 8; i++) drive_bit(b[i], period);
    drive_bit(stop_val, period);
  endtask

  task automatic push(input logic is_err, input logic [7:0] d);
    exp_t e;
    e.is_err = is_err;
    e.data   = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d strobes still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, got, req);
    end
  endtask

  task automatic test_reset();
    #1;
    check_bit("reset_valid", valid, 1'b0);
    check_bit("reset_ferr", frame_err, 1'b0);
    check_bit("reset_busy", busy, 1'b0);
    check_bit("reset_clear", baud_clear, 1'b1);
    checks++;
    if (data !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: got %h required 00", data);
    end
  endtask

  task automatic test_basic();
    int v0 = valid_cnt;
    push(1'b0, 8'h55);
    send_frame(8'h55, M, 1'b1);
    cycles(50);
    wait_drain("basic", 500);
    settle();
    check_bit("basic_busy_idle", busy, 1'b0);
    check_bit("basic_clear_idle", baud_clear, 1'b1);
    checks++;
    if (valid_cnt - v0 != 1 || data !== 8'h55) begin
      errors++;
      $display("FAIL basic_frame: valid pulses %0d data %h, required 1 and 55", valid_cnt - v0, data);
    end
  endtask

  task automatic test_glitch();
    int v0 = valid_cnt;
    int f0 = ferr_cnt;
    rx = 1'b0;
    cycles(10);
    #1;
    check_bit("glitch_busy_start", busy, 1'b1);
    check_bit("glitch_clear_start", baud_clear, 1'b0);
    cycles(10);
    rx = 1'b1;
    cycles(150);
    #1;
    check_bit("glitch_busy_idle", busy, 1'b0);
    check_bit("glitch_clear_idle", baud_clear, 1'b1);
    checks++;
    if (valid_cnt != v0 || ferr_cnt != f0) begin
      errors++;
      $display("FAIL glitch_strobe: valid %0d ferr %0d new pulses, required 0", valid_cnt - v0, ferr_cnt - f0);
    end
  endtask

  task automatic test_frame_err();
    int v0 = valid_cnt;
    int f0 = ferr_cnt;
    push(1'b1, 8'h55);
    send_frame(8'hA3, M, 1'b0);
    cycles(3000);
    #1;
    check_bit("ferr_busy_held", busy, 1'b1);
    check_bit("ferr_clear_held", baud_clear, 1'b1);
    checks++;
    if (ferr_cnt - f0 != 1 || valid_cnt != v0 || data !== 8'h55) begin
      errors++;
      $display("FAIL ferr_break: ferr %0d valid %0d data %h, required 1, 0, 55",
               ferr_cnt - f0, valid_cnt - v0, data);
    end
    wait_drain("ferr", 10);
    rx = 1'b1;
    cycles(10);
    #1;
    check_bit("ferr_busy_released", busy, 1'b0);
    cycles(100);
    push(1'b0, 8'h5A);
    send_frame(8'h5A, M, 1'b1);
    cycles(50);
    wait_drain("ferr_recover", 500);
    checks++;
    if (data !== 8'h5A) begin
      errors++;
      $display("FAIL ferr_recover_data: got %h required 5A", data);
    end
  endtask

  task automatic test_back_to_back();
    int v0 = valid_cnt;
    logic [7:0] seq [3];
    seq[0] = 8'h00;
    seq[1] = 8'hFF;
    seq[2] = 8'h81;
    for (int i = 0; i < 3; i++) begin
      push(1'b0, seq[i]);
      send_frame(seq[i], M, 1'b1);
    end
    cycles(100);
    wait_drain("b2b", 500);
    checks++;
    if (valid_cnt - v0 != 3 || data !== 8'h81) begin
      errors++;
      $display("FAIL b2b_count: valid pulses %0d data %h, required 3 and 81", valid_cnt - v0, data);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b = 8'h3C;
    drive_bit(1'b0, M);
    for (int i = 0; i < 4; i++) drive_bit(b[i], M);
    drive_bit(b[4], M / 2);
    #1;
    check_bit("mid_busy_before", busy, 1'b1);
    #5;
    reset = 1'b0;
    #1;
    check_bit("mid_valid", valid, 1'b0);
    check_bit("mid_ferr", frame_err, 1'b0);
    check_bit("mid_busy", busy, 1'b0);
    check_bit("mid_clear", baud_clear, 1'b1);
    checks++;
    if (data !== 8'h00) begin
      errors++;
      $display("FAIL mid_data: got %h required 00", data);
    end
    rx = 1'b1;
    cycles(5);
    reset = 1'b1;
    cycles(200);
    push(1'b0, 8'h3C);
    send_frame(8'h3C, M, 1'b1);
    cycles(50);
    wait_drain("mid_recover", 500);
    checks++;
    if (data !== 8'h3C) begin
      errors++;
      $display("FAIL mid_recover_data: got %h required 3C", data);
    end
  endtask

  task automatic test_baud_offset();
    int periods [2];
    periods[0] = 102;
    periods[1] = 106;
    for (int i = 0; i < 2; i++) begin
      int f0 = ferr_cnt;
      push(1'b0, 8'hC6);
      send_frame(8'hC6, periods[i], 1'b1);
      cycles(100);
      wait_drain("offset", 500);
      checks++;
      if (data !== 8'hC6 || ferr_cnt != f0) begin
        errors++;
        $display("FAIL offset_%0d: data %h ferr %0d, required C6 and 0", periods[i], data, ferr_cnt - f0);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    rx    = 1'b1;
    cycles(5);
    test_reset();
    @(negedge clk);
    reset = 1'b1;
    cycles(20);
    test_basic();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
    test_baud_offset();
    cycles(20);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver sitting directly downstream of `baudgen`: it synchronises the asynchronous `rx` line, detects the start bit, and holds `baudgen` in reset while idle so that every `baud_tick` lands mid-bit. It then samples 8N1 frames LSB-first and presents each byte with a one-cycle valid strobe, or flags a framing error, to the consuming logic (command/pixel loader).

## Interface
- `DATA_BITS`, 8: data bits per frame (LSB first, no parity, one stop bit).
- `SYNC_STAGES`, 2: flip-flop stages on `rx` (≥2).
- `clk`  in  1  system clock; all logic on posedge.
- `reset`  in  1  one clock; reset is asynchronous and active-low.
- `rx`  in  1  raw serial line; idle high; asynchronous to `clk`.
- `baud_tick`  in  1  one-cycle pulse from `baudgen`, mid-bit when `baudgen` is released from reset at the start-bit edge.
- `baud_clear`  out  1  drives `baudgen.reset` (active-high, synchronous); high = hold bit timer at zero.
- `data`  out  DATA_BITS  last good byte; changes only together with `valid`.
- `valid`  out  1  one-cycle strobe: `data` updated with a good frame.
- `frame_err`  out  1  one-cycle strobe: stop bit sampled low.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- `rx` passes through SYNC_STAGES flops, reset value 1; `rx_s` is the last stage. All sampling uses `rx_s` only.
- States: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: `baud_clear`=1. `rx_s`==0 → START, `baud_clear` drops the same cycle.
- START: on `baud_tick`: `rx_s`==0 → DATA, bit counter=0; `rx_s`==1 (glitch) → IDLE, no strobe.
- DATA: on each `baud_tick` shift `rx_s` into MSB of the shift register (right shift, so the first bit ends at bit 0); increment counter; after bit DATA_BITS-1 → STOP. Counter width $clog2(DATA_BITS); no wrap beyond DATA_BITS-1.
- STOP: on `baud_tick`: `rx_s`==1 → `data`←shift register, `valid`=1, → IDLE. `rx_s`==0 → `frame_err`=1, `data` unchanged, → WAIT_HIGH.
- WAIT_HIGH: `baud_clear`=1; stay until `rx_s`==1, then → IDLE. A held-low line (break) yields exactly one `frame_err`, never repeated frames.
- `baud_clear`=1 in IDLE and WAIT_HIGH and the cycle of any transition into them; 0 in START, DATA, STOP.
- `baud_tick` outside START/DATA/STOP is ignored.
- `busy`=1 in START, DATA, STOP, WAIT_HIGH.

## Timing
- Reset (asserted low, asynchronous): state=IDLE, `data`=0, `valid`=0, `frame_err`=0, `busy`=0, `baud_clear`=1, sync flops=1, shift register=0, counter=0. Reset mid-frame aborts the frame with no strobe.
- Edge detect latency: SYNC_STAGES cycles from `rx` fall to `rx_s` fall; FSM leaves IDLE the next edge.
- With `baudgen` max_count M: first tick ≈ M/2+1 cycles after `baud_clear` drops; subsequent ticks every M cycles.
- `valid`/`frame_err` registered: asserted the cycle after the stop-bit tick, high exactly one cycle; never both.
- Back-to-back frames: a start bit beginning right after the stop bit's mid-point is detected; no idle gap required.
- Outputs registered; no combinational path from `rx` or `baud_tick` to any output.

## Structure
- Package `uart_pkg`: state enumeration, default DATA_BITS, frame constants (start=0, stop=1) shared with a future `uart_tx`.
- Sub-module `rx_sync`: SYNC_STAGES-deep reset-to-1 synchroniser. `baudgen` is instantiated alongside by the parent, not inside `uart_rx`.

## Test plan
Bench: 12 MHz `clk`, `baudgen` at 115200 (M=104), `baud_clear` wired to its reset, bit period 104 cycles.
- Frame 0x55 then idle → one `valid` pulse, `data`=0x55, `frame_err`=0, `busy` back to 0 before next start.
- `rx` low for 20 cycles then high → no `valid`/`frame_err`, FSM returns IDLE after first tick, `baud_clear`=1.
- Data 0xA3 with stop bit driven low, line kept low 3000 cycles → one `frame_err`, `data` keeps previous value, `busy`=1 until `rx` high, then a 0x5A frame decodes correctly.
- Back-to-back 0x00, 0xFF, 0x81 with no idle → three `valid` pulses, `data` 0x00, 0xFF, 0x81 in order.
- `reset` low during data bit 4 of 0x3C → all outputs at reset values immediately; after release, a full 0x3C frame → `valid`, `data`=0x3C.
- Baud offset ±2% (bit period 102 and 106 cycles), frame 0xC6 → `data`=0xC6, no `frame_err`.
